// File: rtl/maze_pkg.sv
// Shared types and constants for the rat-in-maze depth-first search controller.
package maze_pkg;

   localparam int unsigned N_DEF = 4;
   typedef logic [2*N_DEF-1:0] loc_t;
   localparam loc_t GOAL = {(2*N_DEF){1'b1}};

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_MARK  = 4'd1;
   localparam logic [3:0] S_CHK   = 4'd2;
   localparam logic [3:0] S_EVAL  = 4'd3;
   localparam logic [3:0] S_PUSH  = 4'd4;
   localparam logic [3:0] S_MOVE  = 4'd5;
   localparam logic [3:0] S_POP   = 4'd6;
   localparam logic [3:0] S_FOUND = 4'd7;
   localparam logic [3:0] S_FAIL  = 4'd8;

   typedef logic [1:0] dir_t;
   localparam dir_t DIR_RIGHT = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_LEFT  = 2'd2;
   localparam dir_t DIR_UP    = 2'd3;

endpackage

// File: rtl/maze_nbr.sv
// Neighbour of a maze location in a given direction, with an in-bounds flag.
module maze_nbr
   import maze_pkg::*;
#(
   parameter int unsigned N = N_DEF
)(
   input  logic [2*N-1:0] cur_loc,
   input  dir_t           dir,
   output logic [2*N-1:0] nbr_loc,
   output logic           in_bounds
);

   localparam logic [N-1:0] ONE = N'(1'b1);
   localparam logic [N-1:0] MAX = {N{1'b1}};
   localparam logic [N-1:0] MIN = {N{1'b0}};

   logic [N-1:0] row_s;
   logic [N-1:0] col_s;

   assign row_s = cur_loc[2*N-1:N];
   assign col_s = cur_loc[N-1:0];

   // Coordinates wrap at the edges; in_bounds gates every use of nbr_loc.
   always_comb begin
      nbr_loc   = cur_loc;
      in_bounds = 1'b0;
      case (dir)
         DIR_RIGHT: begin
            nbr_loc   = {row_s, col_s + ONE};
            in_bounds = (col_s != MAX);
         end
         DIR_DOWN: begin
            nbr_loc   = {row_s + ONE, col_s};
            in_bounds = (row_s != MAX);
         end
         DIR_LEFT: begin
            nbr_loc   = {row_s, col_s - ONE};
            in_bounds = (col_s != MIN);
         end
         DIR_UP: begin
            nbr_loc   = {row_s - ONE, col_s};
            in_bounds = (row_s != MIN);
         end
         default: begin
            nbr_loc   = cur_loc;
            in_bounds = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/maze_dfs_ctrl.sv
// Depth-first path search controller: drives the location stack and maze memory
// to find a path from (0,0) to the far corner; all outputs come from registers.
module maze_dfs_ctrl
   import maze_pkg::*;
#(
   parameter int unsigned N         = N_DEF,
   parameter int unsigned STK_DEPTH = 256
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic [2*N-1:0] memAdr,
   output logic           memRd,
   input  logic           memDin,
   output logic           memWr,
   output logic           memDout,
   output logic           push,
   output logic           pop,
   output logic           stckDone,
   output logic [2*N-1:0] locIn,
   input  logic [2*N-1:0] locOut,
   input  logic           empStck,
   output logic [2*N-1:0] curLoc,
   output logic           busy,
   output logic           found,
   output logic           fail
);

   localparam int unsigned    DW         = $clog2(STK_DEPTH + 1);
   localparam logic [DW-1:0]  DEPTH_MAX  = DW'(STK_DEPTH);
   localparam logic [DW-1:0]  DEPTH_ONE  = DW'(1'b1);
   localparam logic [DW-1:0]  DEPTH_ZERO = {DW{1'b0}};
   localparam logic [2*N-1:0] LOC_ZERO   = {(2*N){1'b0}};
   localparam logic [2*N-1:0] LOC_GOAL   = {(2*N){1'b1}};

   logic [3:0]     state_r, state_nx_s;
   logic [2*N-1:0] cur_loc_r, cur_loc_nx_s;
   dir_t           dir_r, dir_nx_s;
   logic [DW-1:0]  depth_r, depth_nx_s;

   logic [2*N-1:0] nbr_loc_s, nbr_nx_loc_s;
   logic           nbr_inb_s, nbr_nx_inb_s;

   logic [2*N-1:0] mem_adr_r, mem_adr_nx_s;
   logic           mem_rd_r, mem_wr_r, push_r, pop_r, done_r, busy_r, found_r, fail_r;

   // Neighbour of the current location drives the search decisions.
   maze_nbr #(.N(N)) u_nbr_cur (
      .cur_loc   (cur_loc_r),
      .dir       (dir_r),
      .nbr_loc   (nbr_loc_s),
      .in_bounds (nbr_inb_s)
   );

   // Neighbour of the next location lets the probe address be registered.
   maze_nbr #(.N(N)) u_nbr_nxt (
      .cur_loc   (cur_loc_nx_s),
      .dir       (dir_nx_s),
      .nbr_loc   (nbr_nx_loc_s),
      .in_bounds (nbr_nx_inb_s)
   );

   // Next-state and datapath-register decode of the search FSM.
   always_comb begin
      state_nx_s   = state_r;
      cur_loc_nx_s = cur_loc_r;
      dir_nx_s     = dir_r;
      depth_nx_s   = depth_r;
      case (state_r)
         S_IDLE, S_FOUND, S_FAIL: begin
            if (start) begin
               state_nx_s   = S_MARK;
               cur_loc_nx_s = LOC_ZERO;
               dir_nx_s     = DIR_RIGHT;
               depth_nx_s   = DEPTH_ZERO;
            end else begin
               state_nx_s = state_r;
            end
         end
         S_MARK: begin
            if (cur_loc_r == LOC_GOAL) begin
               state_nx_s = S_FOUND;
            end else begin
               dir_nx_s   = DIR_RIGHT;
               state_nx_s = S_CHK;
            end
         end
         S_CHK: begin
            if (nbr_inb_s) begin
               state_nx_s = S_EVAL;
            end else if (dir_r == DIR_UP) begin
               state_nx_s = S_POP;
            end else begin
               dir_nx_s = dir_r + 2'd1;
            end
         end
         S_EVAL: begin
            if (!memDin) begin
               state_nx_s = S_PUSH;
            end else if (dir_r == DIR_UP) begin
               state_nx_s = S_POP;
            end else begin
               dir_nx_s   = dir_r + 2'd1;
               state_nx_s = S_CHK;
            end
         end
         S_PUSH: begin
            if (depth_r == DEPTH_MAX) begin
               state_nx_s = S_FAIL;
            end else begin
               depth_nx_s = depth_r + DEPTH_ONE;
               state_nx_s = S_MOVE;
            end
         end
         S_MOVE: begin
            cur_loc_nx_s = nbr_loc_s;
            state_nx_s   = S_MARK;
         end
         S_POP: begin
            // Rescanning from RIGHT is safe: every visited cell reads back as blocked.
            if (empStck) begin
               state_nx_s = S_FAIL;
            end else begin
               cur_loc_nx_s = locOut;
               depth_nx_s   = depth_r - DEPTH_ONE;
               dir_nx_s     = DIR_RIGHT;
               state_nx_s   = S_CHK;
            end
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase
   end

   // Probe address for the coming cycle: the neighbour in CHK, otherwise the current cell.
   always_comb begin
      if ((state_nx_s == S_CHK) && nbr_nx_inb_s) begin
         mem_adr_nx_s = nbr_nx_loc_s;
      end else begin
         mem_adr_nx_s = cur_loc_nx_s;
      end
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= S_IDLE;
         cur_loc_r <= LOC_ZERO;
         dir_r     <= DIR_RIGHT;
         depth_r   <= DEPTH_ZERO;
      end else begin
         state_r   <= state_nx_s;
         cur_loc_r <= cur_loc_nx_s;
         dir_r     <= dir_nx_s;
         depth_r   <= depth_nx_s;
      end
   end

   // Strobes are registered from the next state; stack and depth are stable across CHK/EVAL.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_adr_r <= LOC_ZERO;
         mem_rd_r  <= 1'b0;
         mem_wr_r  <= 1'b0;
         push_r    <= 1'b0;
         pop_r     <= 1'b0;
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
         found_r   <= 1'b0;
         fail_r    <= 1'b0;
      end else begin
         mem_adr_r <= mem_adr_nx_s;
         mem_rd_r  <= (state_nx_s == S_CHK) && nbr_nx_inb_s;
         mem_wr_r  <= (state_nx_s == S_MARK);
         push_r    <= (state_nx_s == S_PUSH) && (depth_nx_s != DEPTH_MAX);
         pop_r     <= (state_nx_s == S_POP) && !empStck;
         done_r    <= (state_nx_s == S_FOUND) && (state_r != S_FOUND);
         busy_r    <= (state_nx_s != S_IDLE) && (state_nx_s != S_FOUND) && (state_nx_s != S_FAIL);
         found_r   <= (state_nx_s == S_FOUND);
         fail_r    <= (state_nx_s == S_FAIL);
      end
   end

   assign memAdr   = mem_adr_r;
   assign memRd    = mem_rd_r;
   assign memWr    = mem_wr_r;
   assign memDout  = 1'b1;
   assign push     = push_r;
   assign pop      = pop_r;
   assign stckDone = done_r;
   assign locIn    = cur_loc_r;
   assign curLoc   = cur_loc_r;
   assign busy     = busy_r;
   assign found    = found_r;
   assign fail     = fail_r;

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// Directed bench: two 4x4 controllers (deep and 2-entry stack) with behavioural
// maze memory and location stack models.
module tb_maze_dfs_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start     [2];
   logic [3:0] mem_adr   [2];
   logic [3:0] loc_in    [2];
   logic [3:0] loc_out   [2];
   logic [3:0] cur_loc   [2];
   logic       mem_rd    [2];
   logic       mem_din   [2];
   logic       mem_wr    [2];
   logic       mem_dout  [2];
   logic       push      [2];
   logic       pop       [2];
   logic       stck_done [2];
   logic       emp_stck  [2];
   logic       busy      [2];
   logic       found     [2];
   logic       fail      [2];

   int checks = 0;
   int errors = 0;

   maze_dfs_ctrl #(.N(2), .STK_DEPTH(16)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]),
      .memAdr(mem_adr[0]), .memRd(mem_rd[0]), .memDin(mem_din[0]), .memWr(mem_wr[0]),
      .memDout(mem_dout[0]), .push(push[0]), .pop(pop[0]), .stckDone(stck_done[0]),
      .locIn(loc_in[0]), .locOut(loc_out[0]), .empStck(emp_stck[0]), .curLoc(cur_loc[0]),
      .busy(busy[0]), .found(found[0]), .fail(fail[0])
   );

   maze_dfs_ctrl #(.N(2), .STK_DEPTH(2)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]),
      .memAdr(mem_adr[1]), .memRd(mem_rd[1]), .memDin(mem_din[1]), .memWr(mem_wr[1]),
      .memDout(mem_dout[1]), .push(push[1]), .pop(pop[1]), .stckDone(stck_done[1]),
      .locIn(loc_in[1]), .locOut(loc_out[1]), .empStck(emp_stck[1]), .curLoc(cur_loc[1]),
      .busy(busy[1]), .found(found[1]), .fail(fail[1])
   );

   // Memory and stack models, plus event counters
   logic [15:0] blk  [2];
   logic [15:0] mem  [2];
   logic        clr  [2];
   logic [3:0]  stk  [2][32];
   logic [4:0]  sp   [2];
   int          done_cnt [2];
   int          push_cnt [2];
   int          pop_cnt  [2];
   logic        both_err [2];
   logic        pop_q    [2];
   logic [3:0]  cur_after_pop [2];

   assign emp_stck[0] = (sp[0] == 5'd0);
   assign emp_stck[1] = (sp[1] == 5'd0);
   assign loc_out[0]  = (sp[0] != 5'd0) ? stk[0][sp[0] - 5'd1] : 4'd0;
   assign loc_out[1]  = (sp[1] != 5'd0) ? stk[1][sp[1] - 5'd1] : 4'd0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            sp[i] <= 5'd0; done_cnt[i] <= 0; push_cnt[i] <= 0; pop_cnt[i] <= 0;
            both_err[i] <= 1'b0; pop_q[i] <= 1'b0; cur_after_pop[i] <= 4'd0; mem_din[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (clr[i]) begin
               mem[i] <= blk[i];
               sp[i] <= 5'd0; done_cnt[i] <= 0; push_cnt[i] <= 0; pop_cnt[i] <= 0;
               both_err[i] <= 1'b0; pop_q[i] <= 1'b0; cur_after_pop[i] <= 4'd0;
            end else begin
               if (mem_wr[i]) mem[i][mem_adr[i]] <= mem_dout[i];
               if (mem_rd[i]) mem_din[i] <= mem[i][mem_adr[i]];
               if (push[i] && pop[i]) both_err[i] <= 1'b1;
               if (push[i]) begin
                  stk[i][sp[i]] <= loc_in[i];
                  sp[i] <= sp[i] + 5'd1;
                  push_cnt[i] <= push_cnt[i] + 1;
               end else if (pop[i]) begin
                  sp[i] <= sp[i] - 5'd1;
                  pop_cnt[i] <= pop_cnt[i] + 1;
               end
               pop_q[i] <= pop[i];
               if (pop_q[i]) cur_after_pop[i] <= cur_loc[i];
               if (stck_done[i]) done_cnt[i] <= done_cnt[i] + 1;
            end
         end
      end
   end

   task automatic load_maze(input int i, input logic [15:0] b);
      blk[i] = b;
      clr[i] = 1'b1;
      @(negedge clk);
      clr[i] = 1'b0;
   endtask

   // Pulse start, then count busy cycles until found/fail; start is re-pulsed at poke.
   task automatic run_search(input int i, input int poke, output int cyc);
      bit done;
      cyc = 0;
      done = 1'b0;
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      for (int k = 0; k < 600 && !done; k++) begin
         if (found[i] || fail[i]) begin
            done = 1'b1;
         end else begin
            if (busy[i]) cyc++;
            start[i] = (k == poke) || (k == poke + 1);
            @(negedge clk);
         end
      end
      start[i] = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL search_timeout inst=%0d: no found/fail within 600 cycles", i);
      end
   endtask

   task automatic test_reset;
      logic [20:0] obs;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         obs = {busy[i], found[i], fail[i], mem_rd[i], mem_wr[i], push[i], pop[i],
                stck_done[i], mem_dout[i], mem_adr[i], loc_in[i], cur_loc[i]};
         checks++;
         if (obs !== {8'b0, 1'b1, 12'b0}) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d: got %h expected %h", i, obs, {8'b0, 1'b1, 12'b0});
         end
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Open maze: 3 cells at 5 cycles, 3 cells at 6 (extra right skip at col 3), plus MARK of goal = 34.
   task automatic test_open_path;
      int cyc;
      logic [3:0] exp_p [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd11};
      load_maze(0, 16'h0000);
      run_search(0, -1, cyc);
      checks++;
      if (found[0] !== 1'b1 || fail[0] !== 1'b0) begin
         errors++; $display("FAIL open_status: found=%b fail=%b expected 1 0", found[0], fail[0]);
      end
      checks++;
      if (cyc !== 34) begin errors++; $display("FAIL open_cycles: got %0d expected 34", cyc); end
      repeat (2) @(negedge clk);
      checks++;
      if (done_cnt[0] !== 1) begin errors++; $display("FAIL open_done_pulses: got %0d expected 1", done_cnt[0]); end
      checks++;
      if (sp[0] !== 5'd6) begin errors++; $display("FAIL open_depth: got %0d expected 6", sp[0]); end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (stk[0][k] !== exp_p[k]) begin
            errors++; $display("FAIL open_stack[%0d]: got %h expected %h", k, stk[0][k], exp_p[k]);
         end
      end
      checks++;
      if (both_err[0] !== 1'b0) begin errors++; $display("FAIL open_push_pop_same_cycle: got 1 expected 0"); end
   endtask

   // (0,1) and (1,0) blocked: MARK, 2x(CHK+EVAL), 2 out-of-bounds CHKs, POP = 8 busy cycles.
   task automatic test_blocked;
      int cyc;
      load_maze(0, 16'h0012);
      run_search(0, -1, cyc);
      checks++;
      if (fail[0] !== 1'b1 || found[0] !== 1'b0) begin
         errors++; $display("FAIL blocked_status: fail=%b found=%b expected 1 0", fail[0], found[0]);
      end
      checks++;
      if (push_cnt[0] !== 0) begin errors++; $display("FAIL blocked_pushes: got %0d expected 0", push_cnt[0]); end
      checks++;
      if (cyc !== 8) begin errors++; $display("FAIL blocked_cycles: got %0d expected 8", cyc); end
      checks++;
      if (done_cnt[0] !== 0) begin errors++; $display("FAIL blocked_done: got %0d expected 0", done_cnt[0]); end
   endtask

   // Open cells 00,01,11,12,21,31,32,33; 12 is a dead end, backtrack to 11 then down.
   task automatic test_dead_end;
      int cyc;
      int dups;
      logic [3:0] exp_p [6] = '{4'd0, 4'd1, 4'd5, 4'd9, 4'd13, 4'd14};
      load_maze(0, 16'h1D9C);
      run_search(0, -1, cyc);
      checks++;
      if (found[0] !== 1'b1) begin errors++; $display("FAIL dead_found: got %b expected 1", found[0]); end
      checks++;
      if (pop_cnt[0] !== 1) begin errors++; $display("FAIL dead_pops: got %0d expected 1", pop_cnt[0]); end
      checks++;
      if (cur_after_pop[0] !== 4'd5) begin
         errors++; $display("FAIL dead_pop_curloc: got %h expected 5", cur_after_pop[0]);
      end
      checks++;
      if (push_cnt[0] !== 7 || sp[0] !== 5'd6) begin
         errors++; $display("FAIL dead_push_count: pushes=%0d depth=%0d expected 7 6", push_cnt[0], sp[0]);
      end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (stk[0][k] !== exp_p[k]) begin
            errors++; $display("FAIL dead_stack[%0d]: got %h expected %h", k, stk[0][k], exp_p[k]);
         end
      end
      dups = 0;
      for (int a = 0; a < 6; a++)
         for (int b = a + 1; b < 6; b++)
            if (stk[0][a] === stk[0][b]) dups++;
      checks++;
      if (dups !== 0) begin errors++; $display("FAIL dead_duplicates: got %0d expected 0", dups); end
   endtask

   // Two-entry stack: pushes 00,01, then the third PUSH at 02 fails after 14 busy cycles.
   task automatic test_depth_limit;
      int cyc;
      load_maze(1, 16'h0000);
      run_search(1, -1, cyc);
      checks++;
      if (fail[1] !== 1'b1 || found[1] !== 1'b0) begin
         errors++; $display("FAIL depth_status: fail=%b found=%b expected 1 0", fail[1], found[1]);
      end
      checks++;
      if (push_cnt[1] !== 2 || sp[1] !== 5'd2) begin
         errors++; $display("FAIL depth_pushes: pushes=%0d depth=%0d expected 2 2", push_cnt[1], sp[1]);
      end
      checks++;
      if (stk[1][0] !== 4'd0 || stk[1][1] !== 4'd1) begin
         errors++; $display("FAIL depth_stack: got %h %h expected 0 1", stk[1][0], stk[1][1]);
      end
      checks++;
      if (cyc !== 14) begin errors++; $display("FAIL depth_cycles: got %0d expected 14", cyc); end
   endtask

   task automatic test_reset_mid;
      int cyc;
      logic [20:0] obs;
      load_maze(0, 16'h0000);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_rd[0] !== 1'b1 || mem_adr[0] !== 4'd1) begin
         errors++; $display("FAIL mid_probe: rd=%b adr=%h expected 1 1", mem_rd[0], mem_adr[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      obs = {busy[0], found[0], fail[0], mem_rd[0], mem_wr[0], push[0], pop[0],
             stck_done[0], mem_dout[0], mem_adr[0], loc_in[0], cur_loc[0]};
      checks++;
      if (obs !== {8'b0, 1'b1, 12'b0}) begin
         errors++; $display("FAIL mid_reset_outputs: got %h expected %h", obs, {8'b0, 1'b1, 12'b0});
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      load_maze(0, 16'h0000);
      run_search(0, -1, cyc);
      checks++;
      if (found[0] !== 1'b1 || cyc !== 34) begin
         errors++; $display("FAIL mid_rerun: found=%b cycles=%0d expected 1 34", found[0], cyc);
      end
   endtask

   task automatic test_start_busy;
      int cyc;
      load_maze(0, 16'h0000);
      run_search(0, 5, cyc);
      checks++;
      if (found[0] !== 1'b1 || cyc !== 34) begin
         errors++; $display("FAIL busy_start: found=%b cycles=%0d expected 1 34", found[0], cyc);
      end
      checks++;
      if (sp[0] !== 5'd6 || stk[0][5] !== 4'd11) begin
         errors++; $display("FAIL busy_stack: depth=%0d top=%h expected 6 b", sp[0], stk[0][5]);
      end
   endtask

   task automatic test_restart_found;
      int cyc;
      bit done;
      load_maze(0, 16'h0000);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      checks++;
      if (found[0] !== 1'b0 || busy[0] !== 1'b1) begin
         errors++; $display("FAIL restart_status: found=%b busy=%b expected 0 1", found[0], busy[0]);
      end
      checks++;
      if (cur_loc[0] !== 4'd0 || mem_wr[0] !== 1'b1 || mem_adr[0] !== 4'd0) begin
         errors++; $display("FAIL restart_mark: cur=%h wr=%b adr=%h expected 0 1 0", cur_loc[0], mem_wr[0], mem_adr[0]);
      end
      cyc = 0;
      done = 1'b0;
      for (int k = 0; k < 600 && !done; k++) begin
         if (found[0] || fail[0]) done = 1'b1;
         else begin
            if (busy[0]) cyc++;
            @(negedge clk);
         end
      end
      checks++;
      if (found[0] !== 1'b1 || cyc !== 34 || sp[0] !== 5'd6) begin
         errors++; $display("FAIL restart_rerun: found=%b cycles=%0d depth=%0d expected 1 34 6", found[0], cyc, sp[0]);
      end
   endtask

   initial begin
      start[0] = 1'b0; start[1] = 1'b0;
      clr[0] = 1'b0;   clr[1] = 1'b0;
      blk[0] = 16'h0000; blk[1] = 16'h0000;
      test_reset;
      test_open_path;
      test_blocked;
      test_dead_end;
      test_depth_limit;
      test_reset_mid;
      test_start_busy;
      test_restart_found;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
